// File: rtl/pulse_decoder_if.sv
// Pulse-line bus between a pulse source/consumer and pulse_decoder.
// The master side drives the pulse line and receives the decoded results.
interface pulse_decoder_if #(
  parameter int CNT_W = 4
);
  logic             signal;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport master (output signal, input count, valid, overflow, busy);
  modport slave  (input signal, output count, valid, overflow, busy);
endinterface

// File: rtl/pulse_decoder.sv
// Counts rising edges on a possibly asynchronous pulse line and reports the
// per-burst total once the line has been quiet for GAP cycles.
module pulse_decoder #(
  parameter int CNT_W = 4,
  parameter int GAP   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pulse_decoder_if.slave  bus
);

  localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state;
  logic             sync1, sync2, prev;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap;
  logic             ovf;
  logic             rise;

  assign rise = sync2 & ~prev;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // values from before the edge; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      gap          <= '0;
      ovf          <= 1'b0;
      bus.count    <= '0;
      bus.valid    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      sync1     <= bus.signal;
      sync2     <= sync1;
      prev      <= sync2;
      bus.valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            cnt      <= CNT_W'(1);
            gap      <= '0;
            ovf      <= 1'b0;
            state    <= COUNT;
            bus.busy <= 1'b1;
          end
        end

        COUNT: begin
          if (rise) begin
            gap <= '0;
            // Saturate rather than wrap so an over-long burst is still flagged.
            if (cnt == CNT_MAX) ovf <= 1'b1;
            else                cnt <= cnt + CNT_W'(1);
          end else if (gap != GAP_LAST) begin
            gap <= gap + GAP_W'(1);
          end else begin
            bus.count    <= cnt;
            bus.overflow <= ovf;
            bus.valid    <= 1'b1;
            state        <= IDLE;
            bus.busy     <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
